// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path constants: coefficient widths, saturation limits,
// the Annex K quality-50 quantisation tables and the component selector.
package jpeg_pkg;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 12;
  localparam int SAT_MAX = 2047;
  localparam int SAT_MIN = -2048;

  typedef enum logic {
    COMP_Y = 1'b0,
    COMP_C = 1'b1
  } comp_e;

  typedef logic [7:0] qtab_t [64];

  // Natural (row-major) order, index = row*8 + column.
  localparam qtab_t LUMA_QTAB = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam qtab_t CHROMA_QTAB = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  function automatic logic [7:0] qtab_entry(input comp_e comp, input logic [5:0] idx);
    return (comp == COMP_Y) ? LUMA_QTAB[idx] : CHROMA_QTAB[idx];
  endfunction

endpackage

// File: rtl/dequantize_if.sv
// Row-level bus between the inverse zig-zag, the dequantiser and the IDCT.
interface dequantize_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int CYC_W = 15
);

  logic                    enable_y;
  logic                    enable_cb;
  logic                    enable_cr;
  logic                    enable_dequant;
  logic signed [IN_W-1:0]  input_01, input_02, input_03, input_04;
  logic signed [IN_W-1:0]  input_05, input_06, input_07, input_08;
  logic signed [OUT_W-1:0] output_01, output_02, output_03, output_04;
  logic signed [OUT_W-1:0] output_05, output_06, output_07, output_08;
  logic                    enable_idct;
  logic [2:0]              row_idx;
  logic                    block_done;
  logic [CYC_W-1:0]        dequant_cycle;

  modport master (
    output enable_y, enable_cb, enable_cr, enable_dequant,
    output input_01, input_02, input_03, input_04,
    output input_05, input_06, input_07, input_08,
    input  output_01, output_02, output_03, output_04,
    input  output_05, output_06, output_07, output_08,
    input  enable_idct, row_idx, block_done, dequant_cycle
  );

  modport slave (
    input  enable_y, enable_cb, enable_cr, enable_dequant,
    input  input_01, input_02, input_03, input_04,
    input  input_05, input_06, input_07, input_08,
    output output_01, output_02, output_03, output_04,
    output output_05, output_06, output_07, output_08,
    output enable_idct, row_idx, block_done, dequant_cycle
  );

endinterface

// File: rtl/dequant_table.sv
// Combinational quantisation-table ROM: one row of eight entries for the
// selected component.
module dequant_table
  import jpeg_pkg::*;
(
  input  comp_e      comp_i,
  input  logic [2:0] row_i,
  output logic [7:0] q_o [8]
);

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      q_o[c] = qtab_entry(comp_i, {row_i, 3'(c)});
    end
  end

endmodule

// File: rtl/dequantize.sv
// JPEG dequantiser: multiplies each natural-order row by its quantisation
// table row, saturates to the IDCT input width, two register stages.
module dequantize
  import jpeg_pkg::comp_e;
  import jpeg_pkg::COMP_Y;
  import jpeg_pkg::COMP_C;
  import jpeg_pkg::SAT_MAX;
  import jpeg_pkg::SAT_MIN;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int CYC_W = 15
) (
  input logic         clk,
  input logic         nrst,
  dequantize_if.slave bus
);

  localparam int PROD_W = 16;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [PROD_W-1:0] p);
    if (p > PROD_W'(SAT_MAX)) return OUT_W'(SAT_MAX);
    if (p < PROD_W'(SAT_MIN)) return OUT_W'(SAT_MIN);
    return p[OUT_W-1:0];
  endfunction

  logic                    accept;
  comp_e                   comp_sel;
  comp_e                   comp_cur;
  logic [7:0]              q_tab [8];
  logic signed [IN_W-1:0]  in_row [8];

  logic [2:0]              row_q, row_d;
  comp_e                   comp_q, comp_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;

  logic                    vld_p1_q;
  logic [2:0]              row_p1_q;
  logic signed [IN_W-1:0]  in_p1_q [8];
  logic [7:0]              q_p1_q [8];

  logic signed [PROD_W-1:0] prod_p1 [8];

  logic                    vld_p2_q;
  logic                    done_p2_q;
  logic [2:0]              row_p2_q;
  logic signed [OUT_W-1:0] out_p2_q [8];

  assign accept = bus.enable_dequant;
  assign in_row = '{bus.input_01, bus.input_02, bus.input_03, bus.input_04,
                    bus.input_05, bus.input_06, bus.input_07, bus.input_08};

  // Luma wins over chroma; no select at all falls back to luma.
  assign comp_sel = bus.enable_y                    ? COMP_Y :
                    (bus.enable_cb | bus.enable_cr) ? COMP_C : COMP_Y;
  // Row 0 looks up with the live select so back-to-back blocks need no bubble.
  assign comp_cur = (row_q == 3'd0) ? comp_sel : comp_q;

  dequant_table u_table (
    .comp_i (comp_cur),
    .row_i  (row_q),
    .q_o    (q_tab)
  );

  always_comb begin
    row_d  = row_q;
    comp_d = comp_q;
    cyc_d  = cyc_q;
    if (accept) begin
      row_d = row_q + 3'd1;
      cyc_d = cyc_q + 1'b1;
      if (row_q == 3'd0) comp_d = comp_sel;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_q  <= '0;
      comp_q <= COMP_Y;
      cyc_q  <= '0;
    end else begin
      row_q  <= row_d;
      comp_q <= comp_d;
      cyc_q  <= cyc_d;
    end
  end

  // Stage 1: capture the accepted row with its table entries.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p1_q <= 1'b0;
      row_p1_q <= '0;
      for (int c = 0; c < 8; c++) begin
        in_p1_q[c] <= '0;
        q_p1_q[c]  <= '0;
      end
    end else begin
      vld_p1_q <= accept;
      if (accept) begin
        row_p1_q <= row_q;
        for (int c = 0; c < 8; c++) begin
          in_p1_q[c] <= in_row[c];
          q_p1_q[c]  <= q_tab[c];
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign prod_p1[g] = PROD_W'(in_p1_q[g]) * PROD_W'($signed({1'b0, q_p1_q[g]}));
  end

  // Stage 2: saturated products; data and row number hold between rows.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p2_q  <= 1'b0;
      done_p2_q <= 1'b0;
      row_p2_q  <= '0;
      for (int c = 0; c < 8; c++) out_p2_q[c] <= '0;
    end else begin
      vld_p2_q  <= vld_p1_q;
      done_p2_q <= vld_p1_q && (row_p1_q == 3'd7);
      if (vld_p1_q) begin
        row_p2_q <= row_p1_q;
        for (int c = 0; c < 8; c++) out_p2_q[c] <= sat(prod_p1[c]);
      end
    end
  end

  assign bus.output_01     = out_p2_q[0];
  assign bus.output_02     = out_p2_q[1];
  assign bus.output_03     = out_p2_q[2];
  assign bus.output_04     = out_p2_q[3];
  assign bus.output_05     = out_p2_q[4];
  assign bus.output_06     = out_p2_q[5];
  assign bus.output_07     = out_p2_q[6];
  assign bus.output_08     = out_p2_q[7];
  assign bus.enable_idct   = vld_p2_q;
  assign bus.block_done    = done_p2_q;
  assign bus.row_idx       = row_p2_q;
  assign bus.dequant_cycle = cyc_q;

endmodule

// File: tb/tb_dequantize.sv
// Directed bench for the JPEG dequantiser: reset, luma/chroma rows,
// saturation, stalls, select changes, back-to-back blocks, mid-block reset.
module tb_dequantize;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  dequantize_if bus ();

  dequantize dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam int LUMA0 [8] = '{16, 11, 10, 16, 24, 40, 51, 61};
  localparam int LUMA7 [8] = '{72, 92, 95, 98, 112, 100, 103, 99};
  localparam int CHR0  [8] = '{17, 18, 24, 47, 99, 99, 99, 99};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int c, input int v);
    case (c)
      0: bus.input_01 = 8'(v);
      1: bus.input_02 = 8'(v);
      2: bus.input_03 = 8'(v);
      3: bus.input_04 = 8'(v);
      4: bus.input_05 = 8'(v);
      5: bus.input_06 = 8'(v);
      6: bus.input_07 = 8'(v);
      default: bus.input_08 = 8'(v);
    endcase
  endtask

  task automatic set_all(input int v);
    for (int c = 0; c < 8; c++) set_in(c, v);
  endtask

  task automatic sel(input logic y, input logic cb, input logic cr);
    bus.enable_y  = y;
    bus.enable_cb = cb;
    bus.enable_cr = cr;
  endtask

  function automatic int get_out(input int c);
    case (c)
      0: return int'(bus.output_01);
      1: return int'(bus.output_02);
      2: return int'(bus.output_03);
      3: return int'(bus.output_04);
      4: return int'(bus.output_05);
      5: return int'(bus.output_06);
      6: return int'(bus.output_07);
      default: return int'(bus.output_08);
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_idct"}, int'(bus.enable_idct), 0);
    chk({tag, "_done"}, int'(bus.block_done), 0);
    chk({tag, "_row"}, int'(bus.row_idx), 0);
    chk({tag, "_cyc"}, int'(bus.dequant_cycle), 0);
    for (int c = 0; c < 8; c++) chk($sformatf("%s_out%0d", tag, c), get_out(c), 0);
  endtask

  logic prev_en;

  initial begin
    // Reset held with live random traffic on the inputs.
    bus.enable_dequant = 1'b1;
    sel(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) set_in(c, int'($urandom_range(255)));
    repeat (3) begin
      tick();
      chk_zero("rst_init");
    end
    bus.enable_dequant = 1'b0;
    nrst = 1'b1;
    tick();
    chk("idle_idct", int'(bus.enable_idct), 0);

    // Luma block, all +1: eight pulses on edges 2..9 after the first accept.
    sel(1'b1, 1'b0, 1'b0);
    set_all(1);
    bus.enable_dequant = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 8) bus.enable_dequant = 1'b0;
      chk($sformatf("luma_idct_t%0d", t), int'(bus.enable_idct), (t >= 2 && t <= 9) ? 1 : 0);
      chk($sformatf("luma_done_t%0d", t), int'(bus.block_done), (t == 9) ? 1 : 0);
      if (t >= 2 && t <= 9) chk($sformatf("luma_row_t%0d", t), int'(bus.row_idx), t - 2);
      if (t == 2) for (int c = 0; c < 8; c++) chk($sformatf("luma_r0_c%0d", c), get_out(c), LUMA0[c]);
      if (t == 9) begin
        for (int c = 0; c < 8; c++) chk($sformatf("luma_r7_c%0d", c), get_out(c), LUMA7[c]);
        chk("luma_cyc", int'(bus.dequant_cycle), 8);
      end
      if (t == 10) begin
        chk("luma_hold_out5", get_out(4), 112);
        chk("luma_hold_row", int'(bus.row_idx), 7);
      end
    end

    // Chroma block (Cr), all -1.
    sel(1'b0, 1'b0, 1'b1);
    set_all(-1);
    bus.enable_dequant = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 8) bus.enable_dequant = 1'b0;
      chk($sformatf("chr_idct_t%0d", t), int'(bus.enable_idct), (t >= 2 && t <= 9) ? 1 : 0);
      if (t == 2) for (int c = 0; c < 8; c++) chk($sformatf("chr_r0_c%0d", c), get_out(c), -CHR0[c]);
      if (t == 6) for (int c = 0; c < 8; c++) chk($sformatf("chr_r4_c%0d", c), get_out(c), -99);
      if (t == 9) chk("chr_done", int'(bus.block_done), 1);
    end
    chk("chr_cyc", int'(bus.dequant_cycle), 16);

    // Saturation across three back-to-back blocks: luma, luma, Cb.
    for (int e = 1; e <= 26; e++) begin
      bus.enable_dequant = (e <= 24);
      if (e <= 16) sel(1'b1, 1'b0, 1'b0);
      else         sel(1'b0, 1'b1, 1'b0);
      set_all(0);
      if (e == 8) begin
        set_in(0, 20);
        set_in(4, 127);
      end
      if (e == 16) begin
        set_in(0, -128);
        set_in(1, 127);
        set_in(4, -128);
        set_in(7, 1);
      end
      if (e >= 17) set_all(2);
      tick();
      chk($sformatf("sat_idct_e%0d", e), int'(bus.enable_idct), (e >= 2 && e <= 25) ? 1 : 0);
      if (e == 9) begin
        chk("satA_c0", get_out(0), 1440);
        chk("satA_c4", get_out(4), 2047);
        chk("satA_c1", get_out(1), 0);
        chk("satA_done", int'(bus.block_done), 1);
      end
      if (e == 17) begin
        chk("satB_c0", get_out(0), -2048);
        chk("satB_c1", get_out(1), 2047);
        chk("satB_c4", get_out(4), -2048);
        chk("satB_c7", get_out(7), 99);
        chk("satB_done", int'(bus.block_done), 1);
      end
      if (e == 18) begin
        for (int c = 0; c < 8; c++) chk($sformatf("b2b_r0_c%0d", c), get_out(c), 2 * CHR0[c]);
        chk("b2b_row", int'(bus.row_idx), 0);
        chk("b2b_done", int'(bus.block_done), 0);
      end
    end

    // Stall after row 2; select switches to Cb from row 3 on.
    set_all(1);
    prev_en = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      bus.enable_dequant = (e <= 3) || (e >= 7 && e <= 11);
      if (e >= 4) sel(1'b0, 1'b1, 1'b0);
      else        sel(1'b1, 1'b0, 1'b0);
      tick();
      chk($sformatf("stall_idct_e%0d", e), int'(bus.enable_idct), int'(prev_en));
      prev_en = bus.enable_dequant;
      if (e == 6) begin
        chk("stall_hold_row", int'(bus.row_idx), 2);
        chk("stall_hold_c0", get_out(0), 14);
      end
      if (e == 8) begin
        chk("stall_r3_row", int'(bus.row_idx), 3);
        chk("stall_r3_c0", get_out(0), 14);
        chk("stall_r3_c3", get_out(3), 29);
        chk("stall_r3_c5", get_out(5), 87);
      end
      if (e == 12) begin
        chk("stall_r7_c4", get_out(4), 112);
        chk("stall_r7_done", int'(bus.block_done), 1);
      end
    end

    // Reset after row 5 is accepted, then a fresh Cb block.
    sel(1'b1, 1'b0, 1'b0);
    set_all(1);
    bus.enable_dequant = 1'b1;
    repeat (6) tick();
    nrst = 1'b0;
    bus.enable_dequant = 1'b0;
    #1;
    chk_zero("rst_mid0");
    tick();
    chk_zero("rst_mid1");
    nrst = 1'b1;
    sel(1'b0, 1'b1, 1'b0);
    prev_en = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      bus.enable_dequant = (e <= 8);
      tick();
      chk($sformatf("rst_idct_e%0d", e), int'(bus.enable_idct), int'(prev_en));
      prev_en = bus.enable_dequant;
      if (e >= 2 && e <= 9) chk($sformatf("rst_row_e%0d", e), int'(bus.row_idx), e - 2);
      if (e == 2) begin
        chk("rst_r0_c0", get_out(0), 17);
        chk("rst_r0_c3", get_out(3), 47);
      end
    end
    chk("rst_cyc", int'(bus.dequant_cycle), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
